// File: rtl/io_read_arbiter_n.sv
// ---------------------------------------------------------------------------
// io_read_arbiter_n
//
// Purpose:
//   Merges N_CH peripheral read channels onto one registered read-data port
//   for the Minisys-1A I/O bus. The lowest-index selected channel wins, slow
//   devices are waited on through a per-channel ready line, and the chosen
//   device gets a one-cycle ack when its data has been consumed. io_busy
//   stalls the CPU while a mapped read is in flight.
//
// Optional feature:
//   IO_READ_TIMEOUT_EN - when defined, a WAIT that lasts TIMEOUT cycles without
//   the selected device becoming ready is aborted: io_read_data is loaded with
//   ERR_VALUE and io_valid/io_err pulse. When undefined, WAIT lasts until the
//   device is ready or reset is asserted.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   io_read      in   CPU read request (level)
//   ctrl         in   [N_CH]   per-channel select from the address decoder
//   dev_data     in   [N_CH*W] channel i data at bits [i*W +: W]
//   dev_ready    in   [N_CH]   channel i has valid data
//   dev_ack      out  [N_CH]   one-cycle one-hot pulse, channel data consumed
//   io_read_data out  [W]      registered read data, holds between reads
//   io_valid     out  one-cycle pulse, transaction ended
//   io_err       out  one-cycle pulse with io_valid, unmapped read or timeout
//   io_busy      out  CPU stall request (combinational)
// ---------------------------------------------------------------------------
module io_read_arbiter_n #(
  parameter int             N_CH      = 3,
  parameter int             W         = 16,
  parameter int             TIMEOUT   = 255,
  parameter logic [W-1:0]   ERR_VALUE = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_read,
  input  logic [N_CH-1:0]     ctrl,
  input  logic [N_CH*W-1:0]   dev_data,
  input  logic [N_CH-1:0]     dev_ready,
  output logic [N_CH-1:0]     dev_ack,
  output logic [W-1:0]        io_read_data,
  output logic                io_valid,
  output logic                io_err,
  output logic                io_busy
);

  localparam int SELW = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Reject configurations the design cannot represent at elaboration time.
  if ((N_CH < 1) || (N_CH > 16) || (TIMEOUT < 1)) begin : g_badParam
    $error("io_read_arbiter_n: illegal N_CH or TIMEOUT");
  end

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [SELW-1:0]     r_sel;
  logic [SELW-1:0]     w_selNext;
  logic [W-1:0]        r_data;
  logic [W-1:0]        w_dataNext;
  logic                r_valid;
  logic                w_validNext;
  logic                r_err;
  logic                w_errNext;
  logic [N_CH-1:0]     r_ack;
  logic [N_CH-1:0]     w_ackNext;

  logic [SELW-1:0]     w_lowIdx;
  logic                w_anyCtrl;
  logic                w_request;
  logic                w_accept;
  logic                w_unmapped;
  logic [W-1:0]        w_selData;
  logic                w_selReady;
  logic                w_timeoutHit;

  // A new request is only taken in IDLE and never in the cycle the previous
  // transaction reports io_valid, which gives back-to-back reads a dead cycle.
  assign w_anyCtrl  = |ctrl;
  assign w_request  = (r_state == ST_IDLE) & io_read & ~r_valid;
  assign w_accept   = w_request & w_anyCtrl;
  assign w_unmapped = w_request & ~w_anyCtrl;

  // Priority encoder: scanning from the top down leaves the lowest set bit.
  always_comb begin
    w_lowIdx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ctrl[i]) begin
        w_lowIdx = SELW'(i);
      end
    end
  end

  // Data/ready mux driven by the frozen channel index, so other channels and
  // the decoder are ignored for the whole of WAIT.
  always_comb begin
    w_selData  = '0;
    w_selReady = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_sel == SELW'(i)) begin
        w_selData  = dev_data[i*W +: W];
        w_selReady = dev_ready[i];
      end
    end
  end

`ifdef IO_READ_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Abort only when the device is still not ready on the last allowed cycle;
  // a ready arriving on that same edge takes the capture path instead.
  assign w_timeoutHit = (r_state == ST_WAIT) & ~w_selReady & (r_cnt == CNT_LAST);

  // Wait-cycle counter: cleared when a mapped read is accepted, advanced on
  // every WAIT cycle that neither captures nor aborts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == ST_WAIT) && !w_selReady && !w_timeoutHit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeoutHit = 1'b0;
`endif

  // State and output registers. Everything the CPU or devices see is
  // registered, so io_valid, io_err and dev_ack are clean one-cycle pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ack   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_sel   <= w_selNext;
      r_data  <= w_dataNext;
      r_valid <= w_validNext;
      r_err   <= w_errNext;
      r_ack   <= w_ackNext;
    end
  end

  // Next-state and next-output logic. Pulses default low and the data
  // register defaults to holding, so it only moves on capture or abort.
  always_comb begin
    w_stateNext = r_state;
    w_selNext   = r_sel;
    w_dataNext  = r_data;
    w_validNext = 1'b0;
    w_errNext   = 1'b0;
    w_ackNext   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_selNext   = w_lowIdx;
          w_stateNext = ST_WAIT;
        end else if (w_unmapped) begin
          w_validNext = 1'b1;
          w_errNext   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_selReady) begin
          w_dataNext  = w_selData;
          w_validNext = 1'b1;
          for (int i = 0; i < N_CH; i++) begin
            w_ackNext[i] = (r_sel == SELW'(i));
          end
          w_stateNext = ST_IDLE;
        end else if (w_timeoutHit) begin
          w_dataNext  = ERR_VALUE;
          w_validNext = 1'b1;
          w_errNext   = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Stall covers the accept cycle as well as WAIT so the CPU never runs past
  // a mapped read; unmapped reads complete without a stall.
  assign io_busy = (r_state == ST_WAIT) | w_accept;

  assign io_read_data = r_data;
  assign io_valid     = r_valid;
  assign io_err       = r_err;
  assign dev_ack      = r_ack;

endmodule

// File: tb/tb_io_read_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_io_read_arbiter_n
//
// Self-checking bench for io_read_arbiter_n with N_CH=3, W=16, TIMEOUT=8 and
// ERR_VALUE=16'hDEAD. Each read is described by its select pattern and the
// number of WAIT cycles the chosen device holds ready low; the expected end
// cycle, outcome and read data follow from those two numbers.
// ---------------------------------------------------------------------------
module tb_io_read_arbiter_n;

  localparam int          TB_TIMEOUT = 8;
  localparam logic [15:0] TB_ERR     = 16'hDEAD;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_read;
  logic [2:0]  ctrl;
  logic [47:0] dev_data;
  logic [2:0]  dev_ready;
  logic [2:0]  dev_ack;
  logic [15:0] io_read_data;
  logic        io_valid;
  logic        io_err;
  logic        io_busy;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expData;

  io_read_arbiter_n #(
    .N_CH      (3),
    .W         (16),
    .TIMEOUT   (TB_TIMEOUT),
    .ERR_VALUE (TB_ERR)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_read      (io_read),
    .ctrl         (ctrl),
    .dev_data     (dev_data),
    .dev_ready    (dev_ready),
    .dev_ack      (dev_ack),
    .io_read_data (io_read_data),
    .io_valid     (io_valid),
    .io_err       (io_err),
    .io_busy      (io_busy)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // One comparison: count it, and on mismatch count and report the failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Run one read from an IDLE negedge. The selected device's ready stays low
  // for `d` WAIT cycles; everything else the DUT should ignore is randomised.
  task automatic applyStimulus(input logic [2:0] c, input int d, input logic [47:0] data);
    int         sel;
    int         last;
    bit         capture;
    logic [2:0] expAck;
    sel = -1;
    for (int i = 2; i >= 0; i--) if (c[i]) sel = i;
    capture = 1'b0;
    if (c == 3'b000) begin
      last = 0;
    end else begin
`ifdef IO_READ_TIMEOUT_EN
      if (d >= TB_TIMEOUT) begin
        last = TB_TIMEOUT;
      end else begin
        last = 1 + d;
        capture = 1'b1;
      end
`else
      last = 1 + d;
      capture = 1'b1;
`endif
    end
    for (int k = 0; k <= last; k++) begin
      io_read   = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ctrl      = (k == 0) ? c : 3'($urandom);
      dev_data  = (k == 0) ? data : {16'($urandom), 16'($urandom), 16'($urandom)};
      dev_ready = 3'($urandom);
      if (sel >= 0) begin
        dev_data[sel*16 +: 16] = data[sel*16 +: 16];
        dev_ready[sel] = (k == 0) ? (d == 0) : ((k - 1) >= d);
      end
      #1 checkOutput("busy", {31'b0, io_busy}, (k == 0) ? {31'b0, |c} : 32'd1);
      @(posedge clock);
      #1;
      if (k == last) begin
        if (capture) expData = data[sel*16 +: 16];
        else if (c != 3'b000) expData = TB_ERR;
      end
      expAck = (k == last && capture) ? 3'(1 << sel) : 3'b000;
      checkOutput("valid", {31'b0, io_valid}, {31'b0, k == last});
      checkOutput("err", {31'b0, io_err}, {31'b0, (k == last) && !capture});
      checkOutput("ack", {29'b0, dev_ack}, {29'b0, expAck});
      checkOutput("data", {16'b0, io_read_data}, {16'b0, expData});
      @(negedge clock);
    end
    // Dead cycle: a request held during io_valid must not be accepted.
    io_read   = 1'b1;
    ctrl      = 3'($urandom_range(1, 7));
    dev_ready = 3'b111;
    #1 checkOutput("deadBusy", {31'b0, io_busy}, 32'd0);
    @(posedge clock);
    #1;
    checkOutput("deadValid", {31'b0, io_valid}, 32'd0);
    checkOutput("deadAck", {29'b0, dev_ack}, 32'd0);
    checkOutput("deadData", {16'b0, io_read_data}, {16'b0, expData});
    @(negedge clock);
    io_read = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    io_read   = 1'b0;
    ctrl      = 3'b000;
    dev_data  = '0;
    dev_ready = 3'b000;
    expData   = 16'h0000;
    #3;
    checkOutput("rstValid", {31'b0, io_valid}, 32'd0);
    checkOutput("rstErr", {31'b0, io_err}, 32'd0);
    checkOutput("rstAck", {29'b0, dev_ack}, 32'd0);
    checkOutput("rstData", {16'b0, io_read_data}, 32'd0);
    checkOutput("rstBusy", {31'b0, io_busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] directed reads");
    applyStimulus(3'b010, 0, {16'h0000, 16'h1234, 16'h0000});
    applyStimulus(3'b000, 0, 48'h0);
    applyStimulus(3'b110, 0, {16'h5555, 16'hAAAA, 16'h0000});
    applyStimulus(3'b001, 5, {16'h0101, 16'h0202, 16'h0303});
    applyStimulus(3'b100, TB_TIMEOUT - 1, {16'h7777, 16'h0000, 16'h0000});
    applyStimulus(3'b011, TB_TIMEOUT, {16'h0000, 16'h0000, 16'hBEEF});
    applyStimulus(3'b001, 100, {16'h0000, 16'h0000, 16'h4321});

    $display("[TB] asynchronous reset in WAIT");
    io_read   = 1'b1;
    ctrl      = 3'b001;
    dev_ready = 3'b000;
    dev_data  = {16'h1111, 16'h2222, 16'h3333};
    @(posedge clock);
    @(negedge clock);
    io_read = 1'b0;
    #2 reset = 1'b1;
    #1;
    expData = 16'h0000;
    checkOutput("midRstData", {16'b0, io_read_data}, 32'd0);
    checkOutput("midRstBusy", {31'b0, io_busy}, 32'd0);
    checkOutput("midRstValid", {31'b0, io_valid}, 32'd0);
    dev_ready = 3'b111;
    @(posedge clock);
    #1;
    checkOutput("midRstAck", {29'b0, dev_ack}, 32'd0);
    checkOutput("midRstValid2", {31'b0, io_valid}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] random reads");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(3'($urandom), int'($urandom_range(0, 12)),
                    {16'($urandom), 16'($urandom), 16'($urandom)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
